alu_issue_stage: RTL

- ID/EX issue stage that drives the existing ALU's operand and control inputs; it is the encoder side of the ALU control interface.
- Decodes a fetched RV32 instruction plus register-file operands into data1/data2/ALUCtrl and registers them toward EX.
- Uses a valid/ready handshake, a flush input, and a multiply hold-off counter that models multiply occupying EX for extra cycles.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_ctrl_dec.sv | 43 ++++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control interface: ALU codes, RV32 opcode/funct fields,
// and the hold-off FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADDI = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b0111;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic {
        HOLD_IDLE   = 1'b0,
        HOLD_ACTIVE = 1'b1
    } hold_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decoder from a raw RV32 instruction to the ALU control code,
// the immediate-operand select and the illegal flag.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [3:0]  alu_ctrl_o,
    output logic        use_inst_as_data2_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_inst_bits;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    // Register indices are handled by the issue stage, not here.
    assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

    always_comb begin
        alu_ctrl_o          = ALU_NONE;
        use_inst_as_data2_o = 1'b0;
        illegal_o           = 1'b1;
        if (opcode == OP_RTYPE) begin
            unique case ({f3, f7})
                {F3_ADD_SUB, F7_BASE}: begin alu_ctrl_o = ALU_ADD; illegal_o = 1'b0; end
                {F3_ADD_SUB, F7_SUB}:  begin alu_ctrl_o = ALU_SUB; illegal_o = 1'b0; end
                {F3_ADD_SUB, F7_MUL}:  begin alu_ctrl_o = ALU_MUL; illegal_o = 1'b0; end
                {F3_OR, F7_BASE}:      begin alu_ctrl_o = ALU_OR;  illegal_o = 1'b0; end
                {F3_AND, F7_BASE}:     begin alu_ctrl_o = ALU_AND; illegal_o = 1'b0; end
                default: ;
            endcase
        end else if (opcode == OP_IMM && f3 == F3_ADD_SUB) begin
            alu_ctrl_o          = ALU_ADDI;
            use_inst_as_data2_o = 1'b1;
            illegal_o           = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU: valid/ready handshake, flush, and a
// post-multiply hold-off that keeps new ops out while EX is still busy.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int MUL_HOLD = 2,
    parameter int XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [3:0]      ALUCtrl_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    localparam logic [3:0] HOLD_LOAD = 4'(MUL_HOLD);

    logic [3:0]      dec_ctrl;
    logic            dec_use_inst;
    logic            dec_illegal;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] data1_q, data1_d;
    logic [XLEN-1:0] data2_q, data2_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;

    hold_state_e     state_q;
    logic [3:0]      hold_cnt_q;

    logic            xfer_in;
    logic            xfer_out;
    logic            mul_out;

    alu_ctrl_dec u_dec (
        .inst_i              (inst_i),
        .alu_ctrl_o          (dec_ctrl),
        .use_inst_as_data2_o (dec_use_inst),
        .illegal_o           (dec_illegal)
    );

    assign in_ready_o = (hold_cnt_q == 4'd0) && (!out_valid_q || out_ready_i);
    assign xfer_in    = in_valid_i && in_ready_o;
    assign xfer_out   = out_valid_q && out_ready_i;
    assign mul_out    = xfer_out && (ctrl_q == ALU_MUL);

    always_comb begin
        out_valid_d = out_valid_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        ctrl_d      = ctrl_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (xfer_in) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            rd_d        = inst_i[11:7];
            illegal_d   = dec_illegal;
            data1_d     = dec_illegal ? '0 : rs1_data_i;
            // addi hands the whole word to the ALU, which takes the immediate as inst>>20.
            data2_d     = dec_illegal ? '0 : (dec_use_inst ? inst_i : rs2_data_i);
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            ctrl_q      <= ALU_NONE;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q    <= HOLD_IDLE;
            hold_cnt_q <= 4'd0;
        end else begin
            unique case (state_q)
                HOLD_IDLE: begin
                    if (mul_out && MUL_HOLD > 0) begin
                        state_q    <= HOLD_ACTIVE;
                        hold_cnt_q <= HOLD_LOAD;
                    end
                end
                HOLD_ACTIVE: begin
                    // A mul leaving during the hold restarts it so EX is never overrun.
                    if (mul_out) begin
                        hold_cnt_q <= HOLD_LOAD;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                        if (hold_cnt_q == 4'd1) begin
                            state_q <= HOLD_IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= HOLD_IDLE;
                    hold_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign data1_o     = data1_q;
    assign data2_o     = data2_q;
    assign ALUCtrl_o   = ctrl_q;
    assign rd_o        = rd_q;
    assign illegal_o   = illegal_q && out_valid_q;

endmodule
